cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
Hardware instruction trace buffer for the cpu_logic core. It captures the fetched PC and instruction word into a parametrised circular buffer on every fetch strobe. Capture can run continuously or stop when the buffer is full, and can stop on a PC-match trigger after a programmable number of post-trigger samples. After capture stops, the buffer is drained oldest-first through a read port for on-board debug or bench checking. This replaces $monitor-style PC/instruction observation with a synthesizable block that also works on the FPGA.

Parameters:
DATA_W, 32, width of the PC and instruction fields.
DEPTH, 16, number of trace entries; must be a power of two and at least 2.
PTR_W, $clog2(DEPTH), derived pointer width; not overridden by the user.

Ports:
CLOCK_50  in  1  system clock; all logic is on its rising edge.
KEY  in  1  reset, asynchronous, active-low.
cap_valid  in  1  one-cycle fetch strobe, driven from pc_flag.
cap_pc  in  DATA_W  PC of the fetched instruction.
cap_instr  in  DATA_W  fetched instruction word.
arm  in  1  one-cycle pulse; clears the buffer and starts capture.
mode  in  1  0 = circular (wrap and overwrite), 1 = linear (stop when full); sampled on arm.
trig_en  in  1  enables the PC-match trigger; sampled on arm.
trig_pc  in  DATA_W  trigger PC; sampled on arm.
post_count  in  PTR_W  number of samples kept after the trigger; sampled on arm.
rd_en  in  1  pop request; honoured only in DONE.
rd_pc  out  DATA_W  popped PC.
rd_instr  out  DATA_W  popped instruction.
rd_valid  out  1  rd_pc/rd_instr valid this cycle.
count  out  PTR_W+1  number of entries held.
overflow  out  1  at least one entry was overwritten since arm.
state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE.

Behaviour:
- Reset (KEY=0, asynchronous):
  - state = IDLE; wr_ptr, rd_ptr, count = 0.
  - overflow = 0, rd_valid = 0, rd_pc = 0, rd_instr = 0.
  - Latched mode, trig_en, trig_pc and the post counter are cleared.
- arm (in any state):
  - Next cycle: pointers and count = 0, overflow = 0.
  - mode, trig_en, trig_pc and post_count are latched; state moves to ARMED.
  - arm has priority over a cap_valid or rd_en in the same cycle; that sample or pop is dropped.
- IDLE and DONE: cap_valid is ignored.
- Write (ARMED or POST, on cap_valid):
  - {cap_pc, cap_instr} is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - If count < DEPTH, count increments.
  - If count == DEPTH, the oldest entry is overwritten: rd_ptr increments, count holds, overflow is set sticky.
- ARMED, on cap_valid:
  - If trig_en and cap_pc == trig_pc: the trigger sample is written. With post counter 0 → DONE; otherwise → POST.
  - Else, if mode = 1 and this write makes count == DEPTH → DONE. Linear mode never sets overflow.
  - Otherwise stay in ARMED.
- POST, on cap_valid:
  - Write the sample and decrement the post counter; when it reaches 0 after the write → DONE.
  - In POST, mode is ignored and the buffer is always circular.
  - post_count ≤ DEPTH−1 by width, so the trigger sample is always retained.
- DONE, on rd_en with count > 0:
  - Next cycle: rd_pc/rd_instr = entry at rd_ptr and rd_valid = 1 (1-cycle latency).
  - rd_ptr increments modulo DEPTH; count decrements.
  - Back-to-back rd_en pops one entry per cycle.
- rd_en with count == 0, or outside DONE: no effect; rd_valid = 0.
- rd_valid is high for exactly one cycle per pop. rd_pc/rd_instr hold their last value otherwise.
- Trace storage is plain registers or inferred RAM with a synchronous read port. Storage contents are not reset.

Optional Feature:
CPU_TRACE_TIMESTAMP_EN:
- Defined:
  - A free-running 32-bit cycle counter is added, reset to 0 and wrapping at 2^32.
  - Each entry also stores the counter value at capture.
  - An extra output rd_ts[31:0] is added; it is aligned with rd_pc and reset to 0.
- Undefined: no counter, no rd_ts port, and storage is 2*DATA_W per entry.

Test Plan:
1. Linear fill (DEPTH=16): arm with mode=1, trig_en=0; 20 captures with PC=4*i, instr=0xA000_0000+i → state=3 after the 16th capture, count=16, overflow=0; 16 pops return PC 0x00..0x3C in order, rd_valid one cycle after each rd_en, then count=0.
2. Circular trigger: arm with mode=0, trig_en=1, trig_pc=0x40, post_count=3; captures PC=4*i for i=0..29 → DONE after i=19, later captures ignored; count=16, overflow=1; pops return PC 0x10..0x4C.
3. Immediate trigger: post_count=0, trig_pc=0x08 → DONE the cycle after the PC=0x08 capture; count=3; last pop returns 0x08.
4. Empty and illegal reads: rd_en in ARMED → rd_valid=0 and count unchanged; in DONE, rd_en after the buffer is drained → rd_valid=0 and count stays 0.
5. Collisions: arm together with cap_valid → sample dropped, count=0 next cycle. KEY=0 mid-POST → state=0, count=0, rd_valid=0 immediately, without waiting for a clock edge.
6. With CPU_TRACE_TIMESTAMP_EN: captures on cycles 10, 12 and 17 after reset → rd_ts pops 10, 12, 17, and the differences match the capture spacing.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// rtl/cpu_trace_buffer.sv - PC/instruction trace buffer with linear/circular capture and PC trigger
// Optional macro CPU_TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp per entry and the rd_ts output.
module cpu_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              CLOCK_50,
    input  logic              KEY,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_pc,
    input  logic [DATA_W-1:0] cap_instr,
    input  logic              arm,
    input  logic              mode,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [PTR_W-1:0]  post_count,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_instr,
    output logic              rd_valid,
    output logic [PTR_W:0]    count,
    output logic              overflow,
`ifdef CPU_TRACE_TIMESTAMP_EN
    output logic [31:0]       rd_ts,
`endif
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef CPU_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = 2 * DATA_W + 32;
`else
    localparam int ENTRY_W = 2 * DATA_W;
`endif

    localparam logic [PTR_W:0] FULL_CNT   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ALMOST_CNT = (PTR_W + 1)'(DEPTH - 1);

    state_t              cur_state;
    state_t              nxt_state;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    post_q;
    logic                mode_q;
    logic                trig_en_q;
    logic [DATA_W-1:0]   trig_pc_q;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ENTRY_W-1:0]  wr_entry;

    logic wr_fire;
    logic rd_fire;
    logic full;
    logic trig_hit;

    assign state    = cur_state;
    assign full     = (count == FULL_CNT);
    assign trig_hit = trig_en_q && (cap_pc == trig_pc_q);
    assign wr_fire  = cap_valid && !arm && ((cur_state == S_ARMED) || (cur_state == S_POST));
    assign rd_fire  = rd_en && !arm && (cur_state == S_DONE) && (count != '0);

`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
        end
    end

    assign wr_entry = {ts_cnt, cap_pc, cap_instr};
`else
    assign wr_entry = {cap_pc, cap_instr};
`endif

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // The trigger beats linear-full: a trigger on the last free slot still enters POST.
    always_comb begin
        nxt_state = cur_state;
        if (arm) begin
            nxt_state = S_ARMED;
        end else begin
            case (cur_state)
                S_ARMED: begin
                    if (cap_valid) begin
                        if (trig_hit) begin
                            nxt_state = (post_q == '0) ? S_DONE : S_POST;
                        end else if (mode_q && (count == ALMOST_CNT)) begin
                            nxt_state = S_DONE;
                        end
                    end
                end
                S_POST: begin
                    if (cap_valid && (post_q == PTR_W'(1))) begin
                        nxt_state = S_DONE;
                    end
                end
                default: nxt_state = cur_state;
            endcase
        end
    end

    // Trace storage carries no reset so it can map onto block RAM.
    always_ff @(posedge CLOCK_50) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            post_q    <= '0;
            mode_q    <= 1'b0;
            trig_en_q <= 1'b0;
            trig_pc_q <= '0;
            rd_valid  <= 1'b0;
            rd_pc     <= '0;
            rd_instr  <= '0;
`ifdef CPU_TRACE_TIMESTAMP_EN
            rd_ts     <= '0;
`endif
        end else begin
            rd_valid <= 1'b0;
            if (arm) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                post_q    <= post_count;
                mode_q    <= mode;
                trig_en_q <= trig_en;
                trig_pc_q <= trig_pc;
            end else begin
                if (wr_fire) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    if (full) begin
                        rd_ptr   <= rd_ptr + PTR_W'(1);
                        overflow <= 1'b1;
                    end else begin
                        count <= count + (PTR_W + 1)'(1);
                    end
                    if (cur_state == S_POST) begin
                        post_q <= post_q - PTR_W'(1);
                    end
                end
                if (rd_fire) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    count    <= count - (PTR_W + 1)'(1);
                    rd_valid <= 1'b1;
                    rd_pc    <= mem[rd_ptr][2*DATA_W-1:DATA_W];
                    rd_instr <= mem[rd_ptr][DATA_W-1:0];
`ifdef CPU_TRACE_TIMESTAMP_EN
                    rd_ts    <= mem[rd_ptr][ENTRY_W-1:2*DATA_W];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb/tb_cpu_trace_buffer.sv - scoreboard bench for cpu_trace_buffer
module tb_cpu_trace_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = 4;

    logic              CLOCK_50 = 1'b0;
    logic              KEY = 1'b0;
    logic              cap_valid = 1'b0;
    logic [DATA_W-1:0] cap_pc = '0;
    logic [DATA_W-1:0] cap_instr = '0;
    logic              arm = 1'b0;
    logic              mode = 1'b0;
    logic              trig_en = 1'b0;
    logic [DATA_W-1:0] trig_pc = '0;
    logic [PTR_W-1:0]  post_count = '0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr;
    logic              rd_valid;
    logic [PTR_W:0]    count;
    logic              overflow;
    logic [1:0]        state;
`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [31:0]       rd_ts;
`endif

    cpu_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLOCK_50   (CLOCK_50),
        .KEY        (KEY),
        .cap_valid  (cap_valid),
        .cap_pc     (cap_pc),
        .cap_instr  (cap_instr),
        .arm        (arm),
        .mode       (mode),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_count (post_count),
        .rd_en      (rd_en),
        .rd_pc      (rd_pc),
        .rd_instr   (rd_instr),
        .rd_valid   (rd_valid),
        .count      (count),
        .overflow   (overflow),
`ifdef CPU_TRACE_TIMESTAMP_EN
        .rd_ts      (rd_ts),
`endif
        .state      (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ts;
        bit          chk_ts;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (KEY && rd_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pop: got rd_pc 0x%0h, expected no rd_valid", rd_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_pc", 64'(rd_pc), 64'(e.pc));
                check("rd_instr", 64'(rd_instr), 64'(e.instr));
`ifdef CPU_TRACE_TIMESTAMP_EN
                if (e.chk_ts) check("rd_ts", 64'(rd_ts), 64'(e.ts));
`endif
            end
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc; e.instr = instr; e.ts = '0; e.chk_ts = 1'b0;
        sb.push_back(e);
    endtask

    task automatic do_arm(input logic m, input logic te, input logic [31:0] tpc, input logic [3:0] pc_n);
        arm = 1'b1; mode = m; trig_en = te; trig_pc = tpc; post_count = pc_n;
        @(negedge CLOCK_50);
        arm = 1'b0;
    endtask

    task automatic capture(input logic [31:0] pc, input logic [31:0] instr);
        cap_valid = 1'b1; cap_pc = pc; cap_instr = instr;
        @(negedge CLOCK_50);
        cap_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge CLOCK_50);
        rd_en = 1'b0;
    endtask

    task automatic drain_check(input string name);
        @(negedge CLOCK_50);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_count0"}, 64'(count), 64'd0);
        sb.delete();
    endtask

    initial begin
        #12;
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", {rd_pc, rd_instr}, 64'd0);
        @(negedge CLOCK_50);
        KEY = 1'b1;
        @(negedge CLOCK_50);

        // Linear fill: stops after 16 samples without overflow
        do_arm(1'b1, 1'b0, 32'h0, 4'd0);
        check("t1_armed", 64'(state), 64'd1);
        for (int i = 0; i < 20; i++) begin
            capture(32'(4 * i), 32'hA000_0000 + 32'(i));
            if (i == 15) begin
                check("t1_done", 64'(state), 64'd3);
                check("t1_count", 64'(count), 64'd16);
                check("t1_overflow", 64'(overflow), 64'd0);
            end
        end
        check("t1_count_hold", 64'(count), 64'd16);
        for (int i = 0; i < 16; i++) push_exp(32'(4 * i), 32'hA000_0000 + 32'(i));
        for (int i = 0; i < 16; i++) pop();
        drain_check("t1");

        // Circular with trigger at 0x40 and three post samples
        do_arm(1'b0, 1'b1, 32'h40, 4'd3);
        for (int i = 0; i < 30; i++) begin
            capture(32'(4 * i), 32'hB000_0000 + 32'(i));
            if (i == 16) check("t2_post", 64'(state), 64'd2);
            if (i == 19) check("t2_done", 64'(state), 64'd3);
        end
        check("t2_count", 64'(count), 64'd16);
        check("t2_overflow", 64'(overflow), 64'd1);
        for (int i = 4; i < 20; i++) push_exp(32'(4 * i), 32'hB000_0000 + 32'(i));
        for (int i = 0; i < 16; i++) pop();
        drain_check("t2");

        // Immediate trigger, then reads past empty
        do_arm(1'b0, 1'b1, 32'h08, 4'd0);
        for (int i = 0; i < 5; i++) begin
            capture(32'(4 * i), 32'hC000_0000 + 32'(i));
            if (i == 2) begin
                check("t3_done", 64'(state), 64'd3);
                check("t3_count", 64'(count), 64'd3);
            end
        end
        for (int i = 0; i < 3; i++) push_exp(32'(4 * i), 32'hC000_0000 + 32'(i));
        for (int i = 0; i < 3; i++) pop();
        drain_check("t3");
        pop();
        check("t4_empty_rd_valid", 64'(rd_valid), 64'd0);
        check("t4_empty_count", 64'(count), 64'd0);

        // Pop while ARMED is ignored
        do_arm(1'b0, 1'b0, 32'h0, 4'd0);
        capture(32'h100, 32'hD000_0000);
        capture(32'h104, 32'hD000_0001);
        pop();
        @(negedge CLOCK_50);
        check("t4_armed_rd_valid", 64'(rd_valid), 64'd0);
        check("t4_armed_count", 64'(count), 64'd2);

        // arm beats a simultaneous capture
        arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h200; cap_instr = 32'hE000_0000;
        mode = 1'b0; trig_en = 1'b0;
        @(negedge CLOCK_50);
        arm = 1'b0; cap_valid = 1'b0;
        check("t5_collide_count", 64'(count), 64'd0);
        check("t5_collide_state", 64'(state), 64'd1);

        // Asynchronous reset in POST
        do_arm(1'b0, 1'b1, 32'h04, 4'd5);
        capture(32'h0, 32'h0);
        capture(32'h4, 32'h1);
        capture(32'h8, 32'h2);
        check("t5_in_post", 64'(state), 64'd2);
        #2;
        KEY = 1'b0;
        #1;
        check("t5_rst_state", 64'(state), 64'd0);
        check("t5_rst_count", 64'(count), 64'd0);
        check("t5_rst_rd_valid", 64'(rd_valid), 64'd0);
        @(negedge CLOCK_50);
        KEY = 1'b1;

`ifdef CPU_TRACE_TIMESTAMP_EN
        begin
            int stamps [3];
            stamps[0] = 10; stamps[1] = 12; stamps[2] = 17;
            do_arm(1'b0, 1'b1, 32'h300, 4'd0);
            for (int k = 0; k < 3; k++) begin
                exp_t e;
                for (int w = 0; w < 40 && cyc < stamps[k]; w++) @(negedge CLOCK_50);
                check("t6_cycle_reached", 64'(cyc), 64'(stamps[k]));
                e.pc = 32'h100 * 32'(k + 1); e.instr = 32'hF000_0000 + 32'(k);
                e.ts = 32'(stamps[k]); e.chk_ts = 1'b1;
                sb.push_back(e);
                capture(e.pc, e.instr);
            end
            check("t6_done", 64'(state), 64'd3);
            for (int k = 0; k < 3; k++) pop();
            drain_check("t6");
        end
`endif

        repeat (3) @(negedge CLOCK_50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
